raster_engine: RTL and testbench
================================

// Module: raster_engine
// PURPOSE
//  Parametrised successor to the fixed-width line drawer. Accepts one draw
//  command per handshake and emits a stream of pixels for the framebuffer writer.
//  Two modes are supported. MODE_LINE is Bresenham over all eight octants.
//  MODE_RECT is a filled axis-aligned rectangle in row-major order.
//  Both directions use valid/ready flow control. Pixels outside the screen are
//  clipped. The block sits between the command decoder and the framebuffer port.
// PARAMETERS
//  COORD_W   9    bits per x/y coordinate (unsigned)
//  COLOR_W   8    bits per pixel colour
//  SCREEN_W  320  pixels with x >= SCREEN_W are clipped
//  SCREEN_H  240  pixels with y >= SCREEN_H are clipped
// PORTS
//  clk          in   1          clock; all logic on rising edge
//  reset        in   1          synchronous, active-low reset
//  cmd_valid    in   1          command present
//  cmd_ready    out  1          engine can accept a command
//  cmd_mode     in   1          0 = MODE_LINE, 1 = MODE_RECT
//  x1, y1       in   COORD_W    start point / rectangle corner A
//  x2, y2       in   COORD_W    end point / rectangle corner B
//  color        in   COLOR_W    fill colour
//  pix_valid    out  1          pixel on pix_* is valid
//  pix_ready    in   1          downstream accepts the pixel
//  pix_x        out  COORD_W    pixel x
//  pix_y        out  COORD_W    pixel y
//  pix_color    out  COLOR_W    pixel colour
//  busy         out  1          high from command accept until done
//  done         out  1          one-cycle pulse when the command completes
//  pix_count    out  2*COORD_W  pixels handshaked for the current/last command
// BEHAVIOUR
//  Reset (reset==0 at posedge) takes effect from any state, including mid-draw:
//   - state goes to IDLE; cmd_ready=1; pix_valid=0; busy=0; done=0
//   - pix_x, pix_y, pix_color and pix_count are all 0; the in-flight command is dropped
//  FSM:
//   - IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch all command fields -> SETUP.
//   - SETUP: one cycle, then -> DRAW.
//       LINE: dx=|x2-x1|, dy=-|y2-y1|, sx/sy=+/-1, err=dx+dy.
//       RECT: xmin/xmax/ymin/ymax from corners; cursor=(xmin,ymin).
//   - DRAW: the cursor is the candidate pixel. Clipped candidates advance the cursor
//     with pix_valid=0. Visible candidates drive pix_valid=1, and the cursor advances
//     only on pix_valid && pix_ready. While stalled, pix_* stay stable.
//     When the endpoint is consumed or clipped -> DONE.
//       LINE endpoint = (x2,y2). RECT endpoint = (xmax,ymax).
//   - DONE: done=1 for one cycle; busy=0 next cycle -> IDLE.
//  Latency: accept at cycle N gives the first pix_valid at N+2 (if visible).
//   Throughput is 1 pixel/cycle with pix_ready held high.
//  LINE step: e2=2*err.
//   - if e2 >= dy: err += dy, x += sx
//   - if e2 <= dx: err += dx, y += sy
//   - both may apply in one step
//   - err/dx/dy are signed, COORD_W+2 bits; no overflow possible
//  RECT step: x++ until xmax, then x=xmin and y++. Corners are accepted in any order.
//  Degenerate command (x1==x2, y1==y2): exactly one pixel in either mode.
//  cmd_valid while busy is ignored (cmd_ready=0); no queueing.
//  pix_count: cleared on command accept; increments on each pixel handshake;
//   holds its value after done.
//  Coordinate wrap never occurs: the cursor stops at the endpoint before any increment past it.
// STRUCTURE
//  gpu_pkg:
//   - draw_mode_t enum (MODE_LINE, MODE_RECT)
//   - raster_state_t enum (IDLE, SETUP, DRAW, DONE)
//   - localparam for the default screen size
//  Sub-module bresenham_step: combinational next-(x,y,err) from current state,
//   dx, dy, sx, sy. raster_engine holds the FSM, RECT cursor, clipping and handshakes.
// TESTING
//  1 LINE (0,0)->(5,5), colour FF, pix_ready=1
//    -> (0,0)..(5,5) diagonal, 6 pixels; done at accept+8; pix_count=6
//  2 LINE (10,10)->(15,12), colour AA
//    -> (10,10),(11,10),(12,11),(13,11),(14,12),(15,12)
//  3 LINE (5,5)->(0,0) (negative octant)
//    -> (5,5),(4,4)..(0,0); RECT (4,4)->(2,3)
//    -> (2,3),(3,3),(4,3),(2,4),(3,4),(4,4)
//  4 Backpressure: toggle pix_ready 1/0 each cycle on test 2
//    -> same 6 pixels in order; pix_* stable while stalled; no duplicates or drops
//  5 Clipping: LINE (318,0)->(322,0)
//    -> only (318,0),(319,0) emitted; done still pulses; pix_count=2
//  6 Reset mid-draw: reset=0 during pixel 3 of test 1
//    -> next cycle pix_valid=0, cmd_ready=1, busy=0; a new command then runs cleanly

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types and default sizes for the raster pipeline.
// Contents: draw_mode_t (command mode), raster_state_t (engine FSM states),
// default coordinate/colour widths and screen dimensions.
package gpu_pkg;

  localparam int unsigned DEF_COORD_W  = 9;
  localparam int unsigned DEF_COLOR_W  = 8;
  localparam int unsigned DEF_SCREEN_W = 320;
  localparam int unsigned DEF_SCREEN_H = 240;

  typedef enum logic {
    MODE_LINE = 1'b0,
    MODE_RECT = 1'b1
  } draw_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } raster_state_t;

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham step: next cursor and error term from the current ones.
// Ports:
//   x, y        in   current cursor
//   err         in   current error term (signed)
//   dx, dy      in   |x2-x1| and -|y2-y1| (signed)
//   sx, sy      in   step direction, 1 = decrement
//   nx_c, ny_c  out  next cursor (combinational)
//   nerr_c      out  next error term (combinational)
module bresenham_step #(
  parameter int unsigned COORD_W = 9
) (
  input  logic [COORD_W-1:0]        x,
  input  logic [COORD_W-1:0]        y,
  input  logic signed [COORD_W+1:0] err,
  input  logic signed [COORD_W+1:0] dx,
  input  logic signed [COORD_W+1:0] dy,
  input  logic                      sx,
  input  logic                      sy,
  output logic [COORD_W-1:0]        nx_c,
  output logic [COORD_W-1:0]        ny_c,
  output logic signed [COORD_W+1:0] nerr_c
);

  localparam int unsigned EW = COORD_W + 2;

  // One extra bit so 2*err and the accumulated sum cannot overflow.
  logic signed [EW:0] e2;
  logic signed [EW:0] acc;
  logic signed [EW:0] dx_w;
  logic signed [EW:0] dy_w;

  always_comb begin
    e2   = $signed({err, 1'b0});
    dx_w = $signed({dx[EW-1], dx});
    dy_w = $signed({dy[EW-1], dy});
    acc  = $signed({err[EW-1], err});
    nx_c = x;
    ny_c = y;
    if (e2 >= dy_w) begin
      acc  = acc + dy_w;
      nx_c = sx ? (x - COORD_W'(1)) : (x + COORD_W'(1));
    end
    if (e2 <= dx_w) begin
      acc  = acc + dx_w;
      ny_c = sy ? (y - COORD_W'(1)) : (y + COORD_W'(1));
    end
    nerr_c = $signed(acc[EW-1:0]);
  end

endmodule

// File: rtl/raster_engine.sv
// Draw-command rasteriser: Bresenham lines (all octants) and filled
// rectangles, emitted one pixel per handshake with off-screen pixels clipped.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_mode, x1, y1, x2, y2    mode (0 line, 1 rect) and endpoints/corners
//   color                       fill colour
//   pix_valid/pix_ready         pixel handshake
//   pix_x, pix_y, pix_color     pixel payload
//   busy, done                  command in flight / one-cycle completion pulse
//   pix_count                   pixels handshaked for the current/last command
module raster_engine
  import gpu_pkg::*;
#(
  parameter int unsigned COORD_W  = DEF_COORD_W,
  parameter int unsigned COLOR_W  = DEF_COLOR_W,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_mode,
  input  logic [COORD_W-1:0]     x1,
  input  logic [COORD_W-1:0]     y1,
  input  logic [COORD_W-1:0]     x2,
  input  logic [COORD_W-1:0]     y2,
  input  logic [COLOR_W-1:0]     color,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [COORD_W-1:0]     pix_x,
  output logic [COORD_W-1:0]     pix_y,
  output logic [COLOR_W-1:0]     pix_color,
  output logic                   busy,
  output logic                   done,
  output logic [2*COORD_W-1:0]   pix_count
);

  localparam int unsigned EW = COORD_W + 2;
  localparam int unsigned CW = 2 * COORD_W;

  raster_state_t        state_q, state_d;
  draw_mode_t           mode_q, mode_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pix_valid_q, pix_valid_d;
  logic [COORD_W-1:0]   pix_x_q, pix_x_d;
  logic [COORD_W-1:0]   pix_y_q, pix_y_d;
  logic [COLOR_W-1:0]   pix_color_q, pix_color_d;
  logic [CW-1:0]        pix_count_q, pix_count_d;
  logic [COORD_W-1:0]   ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d;
  logic [COORD_W-1:0]   end_x_q, end_x_d, end_y_q, end_y_d, row_x_q, row_x_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                 sx_q, sx_d, sy_q, sy_d;

  logic [COORD_W-1:0]   xmin_c, xmax_c, ymin_c, ymax_c, adx_c, ady_c;
  logic [COORD_W-1:0]   lx_c, ly_c, nx_c, ny_c;
  logic signed [EW-1:0] lerr_c;
  logic                 at_end_c, advance_c;

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign pix_count = pix_count_q;

  function automatic logic on_screen(input logic [COORD_W-1:0] px,
                                     input logic [COORD_W-1:0] py);
    return (32'(px) < SCREEN_W) && (32'(py) < SCREEN_H);
  endfunction

  bresenham_step #(.COORD_W(COORD_W)) u_step (
    .x      (pix_x_q),
    .y      (pix_y_q),
    .err    (err_q),
    .dx     (dx_q),
    .dy     (dy_q),
    .sx     (sx_q),
    .sy     (sy_q),
    .nx_c   (lx_c),
    .ny_c   (ly_c),
    .nerr_c (lerr_c)
  );

  // Next-state, cursor and output computation.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pix_valid_d = pix_valid_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    pix_count_d = pix_count_q;
    ax_d        = ax_q;
    ay_d        = ay_q;
    bx_d        = bx_q;
    by_d        = by_q;
    end_x_d     = end_x_q;
    end_y_d     = end_y_q;
    row_x_d     = row_x_q;
    color_d     = color_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    sx_d        = sx_q;
    sy_d        = sy_q;

    xmin_c    = (ax_q < bx_q) ? ax_q : bx_q;
    xmax_c    = (ax_q < bx_q) ? bx_q : ax_q;
    ymin_c    = (ay_q < by_q) ? ay_q : by_q;
    ymax_c    = (ay_q < by_q) ? by_q : ay_q;
    adx_c     = xmax_c - xmin_c;
    ady_c     = ymax_c - ymin_c;
    at_end_c  = (pix_x_q == end_x_q) && (pix_y_q == end_y_q);
    // A clipped candidate never waits for the consumer.
    advance_c = !pix_valid_q || pix_ready;

    // Row-major walk for rectangles, Bresenham step for lines.
    if (mode_q == MODE_RECT) begin
      if (pix_x_q == end_x_q) begin
        nx_c = row_x_q;
        ny_c = pix_y_q + COORD_W'(1);
      end else begin
        nx_c = pix_x_q + COORD_W'(1);
        ny_c = pix_y_q;
      end
    end else begin
      nx_c = lx_c;
      ny_c = ly_c;
    end

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          mode_d      = draw_mode_t'(cmd_mode);
          ax_d        = x1;
          ay_d        = y1;
          bx_d        = x2;
          by_d        = y2;
          color_d     = color;
          pix_count_d = '0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        pix_color_d = color_q;
        if (mode_q == MODE_RECT) begin
          pix_x_d = xmin_c;
          pix_y_d = ymin_c;
          row_x_d = xmin_c;
          end_x_d = xmax_c;
          end_y_d = ymax_c;
        end else begin
          pix_x_d = ax_q;
          pix_y_d = ay_q;
          end_x_d = bx_q;
          end_y_d = by_q;
          dx_d    = $signed(EW'(adx_c));
          dy_d    = -$signed(EW'(ady_c));
          err_d   = dx_d + dy_d;
          sx_d    = bx_q < ax_q;
          sy_d    = by_q < ay_q;
        end
        pix_valid_d = on_screen(pix_x_d, pix_y_d);
        state_d     = DRAW;
      end
      DRAW: begin
        if (pix_valid_q && pix_ready) begin
          pix_count_d = pix_count_q + CW'(1);
        end
        if (advance_c) begin
          if (at_end_c) begin
            pix_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            pix_x_d     = nx_c;
            pix_y_d     = ny_c;
            pix_valid_d = on_screen(nx_c, ny_c);
            if (mode_q == MODE_LINE) begin
              err_d = lerr_c;
            end
          end
        end
      end
      DONE: begin
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins from any state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_LINE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      pix_count_q <= '0;
      ax_q        <= '0;
      ay_q        <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      end_x_q     <= '0;
      end_y_q     <= '0;
      row_x_q     <= '0;
      color_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      pix_count_q <= pix_count_d;
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      end_x_q     <= end_x_d;
      end_y_q     <= end_y_d;
      row_x_q     <= row_x_d;
      color_q     <= color_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      err_q       <= err_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
    end
  end

endmodule

// File: tb/tb_raster_engine.sv
// Self-checking bench for raster_engine: a queue-based pixel model built from
// the line/rectangle rules, a per-cycle compare process, directed cases and
// randomized commands under random backpressure.
module tb_raster_engine;

  localparam int unsigned COORD_W = 9;
  localparam int unsigned COLOR_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] c;
  } pix_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic                 cmd_mode = 1'b0;
  logic [COORD_W-1:0]   x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic [COLOR_W-1:0]   color = '0;
  logic                 pix_valid;
  logic                 pix_ready = 1'b1;
  logic [COORD_W-1:0]   pix_x, pix_y;
  logic [COLOR_W-1:0]   pix_color;
  logic                 busy, done;
  logic [2*COORD_W-1:0] pix_count;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  int   rdy_mode = 0;

  always #5 clk = ~clk;

  raster_engine dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .x1        (x1),
    .y1        (y1),
    .x2        (x2),
    .y2        (y2),
    .color     (color),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .busy      (busy),
    .done      (done),
    .pix_count (pix_count)
  );

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Consumer: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ~pix_ready;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Per-cycle output check against the expected pixel stream.
  pix_t prev;
  bit   stall_prev = 1'b0;
  always @(negedge clk) begin
    pix_t e;
    if (chk_en) begin
      if (pix_valid) begin
        if (stall_prev) begin
          checks++;
          if ({pix_x, pix_y, pix_color} != prev) begin
            errors++;
            $display("FAIL stall_stable got %h want %h", {pix_x, pix_y, pix_color}, prev);
          end
        end
        if (pix_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_pixel got (%0d,%0d,%h) want none", pix_x, pix_y, pix_color);
          end else begin
            e = exp_q.pop_front();
            if ({pix_x, pix_y, pix_color} != e) begin
              errors++;
              $display("FAIL pixel got (%0d,%0d,%h) want (%0d,%0d,%h)",
                       pix_x, pix_y, pix_color, e.x, e.y, e.c);
            end
          end
        end
      end
      stall_prev = pix_valid && !pix_ready;
      prev       = {pix_x, pix_y, pix_color};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic add_cand(input int x, input int y, input int c,
                          inout int ncand, inout int nvis, inout bit fv);
    pix_t p;
    ncand++;
    if (x >= 0 && x < 320 && y >= 0 && y < 240) begin
      if (ncand == 1) fv = 1'b1;
      nvis++;
      p.x = COORD_W'(x);
      p.y = COORD_W'(y);
      p.c = COLOR_W'(c);
      exp_q.push_back(p);
    end
  endtask

  // Reference: enumerate candidate pixels, queue the visible ones.
  task automatic model_cmd(input bit mode, input int ax, input int ay, input int bx,
                           input int by, input int c,
                           output int ncand, output int nvis, output bit fv);
    int x, y, dx, dy, sx, sy, err, e2;
    ncand = 0;
    nvis  = 0;
    fv    = 1'b0;
    if (!mode) begin
      x   = ax;
      y   = ay;
      dx  = (bx > ax) ? bx - ax : ax - bx;
      dy  = -((by > ay) ? by - ay : ay - by);
      sx  = (ax < bx) ? 1 : -1;
      sy  = (ay < by) ? 1 : -1;
      err = dx + dy;
      while (ncand < 4000) begin
        add_cand(x, y, c, ncand, nvis, fv);
        if (x == bx && y == by) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end else begin
      for (int yy = (ay < by ? ay : by); yy <= (ay < by ? by : ay); yy++)
        for (int xx = (ax < bx ? ax : bx); xx <= (ax < bx ? bx : ax); xx++)
          add_cand(xx, yy, c, ncand, nvis, fv);
    end
  endtask

  // Compare the model queue with a hand-computed 6-pixel list.
  task automatic pin_model(input string nm, input int xs[6], input int ys[6]);
    chk({nm, "_len"}, exp_q.size(), 6);
    for (int i = 0; i < 6 && i < exp_q.size(); i++) begin
      chk({nm, "_x"}, exp_q[i].x, xs[i]);
      chk({nm, "_y"}, exp_q[i].y, ys[i]);
    end
    exp_q.delete();
  endtask

  task automatic send_cmd(input bit mode, input int ax, input int ay, input int bx,
                          input int by, input int c);
    int t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    x1 = COORD_W'(ax); y1 = COORD_W'(ay);
    x2 = COORD_W'(bx); y2 = COORD_W'(by);
    color = COLOR_W'(c);
    @(posedge clk);
    #1;
  endtask

  // Run one command; hold keeps cmd_valid high with junk fields while busy.
  task automatic run_cmd(input bit mode, input int ax, input int ay, input int bx,
                         input int by, input int c, input bit hold, input bit chk_lat);
    int ncand, nvis, j, budget;
    bit fv, got;
    model_cmd(mode, ax, ay, bx, by, c, ncand, nvis, fv);
    send_cmd(mode, ax, ay, bx, by, c);
    if (hold) begin
      cmd_mode = ~mode;
      x1 = 9'd7; y1 = 9'd3; x2 = 9'd1; y2 = 9'd9;
    end else begin
      cmd_valid = 1'b0;
    end
    budget = 4 * ncand + 50;
    j = 0;
    got = 1'b0;
    while (j < budget && !got) begin
      @(negedge clk);
      j++;
      if (j == 1) begin
        chk("busy_after_accept", busy, 1);
        chk("cmd_ready_after_accept", cmd_ready, 0);
      end
      if (j == 2 && chk_lat && fv) chk("first_pix_latency", pix_valid, 1);
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    if (chk_lat) chk("done_latency", j, 2 + ncand);
    chk("pix_count", pix_count, nvis);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("busy_after_done", busy, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("pix_count_hold", pix_count, nvis);
  endtask

  initial begin
    int n, v, t;
    bit f;
    int ax, ay, bx, by, xb, yb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_count", pix_count, 0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;

    // Model pins: the two hand-worked sequences.
    model_cmd(1'b0, 10, 10, 15, 12, 'hAA, n, v, f);
    pin_model("model_line2", '{10, 11, 12, 13, 14, 15}, '{10, 10, 11, 11, 12, 12});
    model_cmd(1'b1, 4, 4, 2, 3, 'h55, n, v, f);
    pin_model("model_rect3", '{2, 3, 4, 2, 3, 4}, '{3, 3, 3, 4, 4, 4});

    rdy_mode = 0;
    run_cmd(1'b0, 0, 0, 5, 5, 'hFF, 1'b0, 1'b1);
    run_cmd(1'b0, 10, 10, 15, 12, 'hAA, 1'b0, 1'b1);
    run_cmd(1'b0, 5, 5, 0, 0, 'h33, 1'b0, 1'b1);
    run_cmd(1'b1, 4, 4, 2, 3, 'h55, 1'b0, 1'b1);
    run_cmd(1'b0, 7, 7, 7, 7, 'h11, 1'b0, 1'b1);
    run_cmd(1'b1, 7, 7, 7, 7, 'h22, 1'b0, 1'b1);

    // Backpressure, with cmd_valid held high while busy.
    rdy_mode = 1;
    run_cmd(1'b0, 10, 10, 15, 12, 'hAA, 1'b1, 1'b0);

    // Clipping at the right and bottom-right edges.
    rdy_mode = 0;
    run_cmd(1'b0, 318, 0, 322, 0, 'h77, 1'b0, 1'b1);
    run_cmd(1'b1, 321, 241, 318, 238, 'h66, 1'b0, 1'b1);

    // Reset while the third pixel of a diagonal is on the bus.
    model_cmd(1'b0, 0, 0, 5, 5, 'hFF, n, v, f);
    send_cmd(1'b0, 0, 0, 5, 5, 'hFF);
    cmd_valid = 1'b0;
    t = 0;
    while (exp_q.size() > 4 && t < 40) begin @(negedge clk); t++; end
    chk("reset_reach_pix3", exp_q.size(), 4);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    reset  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_pix_valid", pix_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_pix_x", pix_x, 0);
    chk("midrst_pix_y", pix_y, 0);
    chk("midrst_pix_color", pix_color, 0);
    chk("midrst_pix_count", pix_count, 0);
    exp_q.delete();
    chk_en = 1'b1;
    run_cmd(1'b0, 0, 0, 5, 5, 'hFF, 1'b0, 1'b1);

    // Randomized commands near the origin, mid-screen and the clip edges.
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       xb = 0;
        1:       xb = 100;
        default: xb = 305;
      endcase
      case ($urandom_range(0, 2))
        0:       yb = 0;
        1:       yb = 50;
        default: yb = 228;
      endcase
      ax = xb + int'($urandom_range(0, 15));
      bx = xb + int'($urandom_range(0, 15));
      ay = yb + int'($urandom_range(0, 15));
      by = yb + int'($urandom_range(0, 15));
      run_cmd(1'($urandom_range(0, 1)), ax, ay, bx, by, int'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
